// File: rtl/mina_memarb_pkg.sv
// Shared definitions for the minaret memory arbiter: bus widths, mask constants,
// state encoding and an address-alignment helper.
package mina_memarb_pkg;

    localparam int unsigned W_ADDR = 32;
    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_MASK = 4;
    localparam int unsigned W_CNT  = 8;

    localparam logic [W_MASK-1:0] M_FETCH = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Word address from the upper address bits; the bus never sees byte offsets.
    function automatic logic [W_ADDR-1:0] word_align(input logic [W_ADDR-3:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/mina_memarb_if.sv
// Bundle of the core fetch port, core data port, shared memory bus and error flag.
// The arbiter uses the slave view; the environment (core + memory) uses the master view.
interface mina_memarb_if;
    import mina_memarb_pkg::*;

    logic              imem_valid;
    logic [W_ADDR-1:0] imem_addr;
    logic              imem_ready;
    logic [W_DATA-1:0] imem_rdata;

    logic              dmem_valid;
    logic [W_ADDR-1:0] dmem_addr;
    logic [W_MASK-1:0] dmem_wmask;
    logic [W_DATA-1:0] dmem_wdata;
    logic [W_MASK-1:0] dmem_rmask;
    logic              dmem_ready;
    logic [W_DATA-1:0] dmem_rdata;

    logic              mem_req;
    logic [W_ADDR-1:0] mem_addr;
    logic [W_MASK-1:0] mem_wmask;
    logic [W_DATA-1:0] mem_wdata;
    logic              mem_ack;
    logic [W_DATA-1:0] mem_rdata;

    logic              bus_err;

    modport slave (
        input  imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wmask, dmem_wdata,
               dmem_rmask, mem_ack, mem_rdata,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata, mem_req, mem_addr,
               mem_wmask, mem_wdata, bus_err
    );

    modport master (
        output imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wmask, dmem_wdata,
               dmem_rmask, mem_ack, mem_rdata,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata, mem_req, mem_addr,
               mem_wmask, mem_wdata, bus_err
    );

endinterface

// File: rtl/mina_memarb_wdog.sv
// Wait-cycle watchdog: expired is high during the TIMEOUT-th enabled cycle after clear.
module mina_wdog import mina_memarb_pkg::*; #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W_EXT = W_CNT + 1;

    logic [W_CNT-1:0] count;

    // expired is precomputed one cycle ahead so it can be a plain register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= (TIMEOUT == 1);
        end else if (enable) begin
            count   <= count + W_CNT'(1);
            expired <= (W_EXT'(count) + W_EXT'(2)) == W_EXT'(TIMEOUT);
        end
    end

endmodule

// File: rtl/mina_memarb.sv
// Two-port (fetch/data) arbiter onto one shared memory bus with data priority,
// a per-transaction ack watchdog and a sticky abort flag.
module mina_memarb import mina_memarb_pkg::*; #(
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [W_DATA-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         reset,
    mina_memarb_if.slave bus
);

    state_e            state_q, state_d;
    logic              hold_i, hold_d;
    logic              i_req, d_req, busy, grant, done;
    logic              wd_expired;
    logic              req_nxt, ri_nxt, rd_nxt, err_nxt;
    logic [W_DATA-1:0] cap_data;
    logic              unused_bits;

    // The core keeps valid up for one cycle after ready; that cycle is not a new request.
    assign i_req    = bus.imem_valid & ~hold_i;
    assign d_req    = bus.dmem_valid & ~hold_d;
    assign busy     = (state_q == ST_IBUS) || (state_q == ST_DBUS);
    assign grant    = (state_q == ST_IDLE) && (i_req || d_req);
    assign done     = busy && (bus.mem_ack || wd_expired);
    assign cap_data = bus.mem_ack ? bus.mem_rdata : ERR_DATA;

    assign unused_bits = ^{bus.imem_addr[1:0], bus.dmem_addr[1:0], bus.dmem_rmask};

    mina_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant),
        .enable  (busy & ~bus.mem_ack),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_req)      state_d = ST_DBUS;
                else if (i_req) state_d = ST_IBUS;
            end
            ST_IBUS, ST_DBUS: if (done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ack wins over a watchdog expiry in the same cycle.
    always_comb begin
        req_nxt = bus.mem_req;
        ri_nxt  = 1'b0;
        rd_nxt  = 1'b0;
        err_nxt = bus.bus_err;
        case (state_q)
            ST_IDLE: req_nxt = grant;
            ST_IBUS, ST_DBUS: begin
                if (done) begin
                    req_nxt = 1'b0;
                    ri_nxt  = (state_q == ST_IBUS);
                    rd_nxt  = (state_q == ST_DBUS);
                    err_nxt = bus.bus_err | ~bus.mem_ack;
                end
            end
            default: req_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wmask  <= '0;
            bus.mem_wdata  <= '0;
            bus.imem_ready <= 1'b0;
            bus.dmem_ready <= 1'b0;
            bus.imem_rdata <= '0;
            bus.dmem_rdata <= '0;
            bus.bus_err    <= 1'b0;
            hold_i         <= 1'b0;
            hold_d         <= 1'b0;
        end else begin
            bus.mem_req    <= req_nxt;
            bus.imem_ready <= ri_nxt;
            bus.dmem_ready <= rd_nxt;
            bus.bus_err    <= err_nxt;
            hold_i         <= bus.imem_ready;
            hold_d         <= bus.dmem_ready;
            if (grant) begin
                if (d_req) begin
                    bus.mem_addr  <= word_align(bus.dmem_addr[W_ADDR-1:2]);
                    bus.mem_wmask <= bus.dmem_wmask;
                    bus.mem_wdata <= bus.dmem_wdata;
                end else begin
                    bus.mem_addr  <= word_align(bus.imem_addr[W_ADDR-1:2]);
                    bus.mem_wmask <= M_FETCH;
                    bus.mem_wdata <= '0;
                end
            end
            if (done && (state_q == ST_IBUS)) bus.imem_rdata <= cap_data;
            if (done && (state_q == ST_DBUS)) bus.dmem_rdata <= cap_data;
        end
    end

endmodule

// File: tb/tb_mina_memarb.sv
// Bench for mina_memarb: directed scenarios then random fetch/data/collision traffic,
// each checked cycle by cycle against a transaction-level timing and memory model.
module tb_mina_memarb;
    import mina_memarb_pkg::*;

    localparam int unsigned TMO  = 4;
    localparam logic [31:0] ERRW = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   scen  = 0;
    logic err_m;
    logic [31:0] mem_m [logic [29:0]];

    always #5 clk = ~clk;

    mina_memarb_if bus ();

    mina_memarb #(.TIMEOUT(TMO), .ERR_DATA(ERRW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s scen=%0d: observed %h expected %h", tag, scen, obs, exp);
        end
    endtask

    task automatic chk_rst();
        chk("rst_mem_req",    32'(bus.mem_req),    32'h0);
        chk("rst_mem_addr",   bus.mem_addr,        32'h0);
        chk("rst_mem_wmask",  32'(bus.mem_wmask),  32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata,       32'h0);
        chk("rst_imem_ready", 32'(bus.imem_ready), 32'h0);
        chk("rst_dmem_ready", 32'(bus.dmem_ready), 32'h0);
        chk("rst_imem_rdata", bus.imem_rdata,      32'h0);
        chk("rst_dmem_rdata", bus.dmem_rdata,      32'h0);
        chk("rst_bus_err",    32'(bus.bus_err),    32'h0);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem_m.exists(a[31:2])) mem_m[a[31:2]] = $urandom;
        return mem_m[a[31:2]];
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_m[a[31:2]] = w;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_m[a[31:2]] = d;
    endtask

    // w = ack in the w-th cycle of mem_req (1..TMO); 0 = memory never acks.
    function automatic int pick_w();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(1, 4));
    endfunction

    // Valid(s) rise in cycle 0; data is served first, the fetch is granted the cycle after
    // the data ready pulse; every request costs grant + wait cycles + one response cycle.
    task automatic run_scen(input bit has_i, input bit has_d, input logic [31:0] ia,
                            input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dw,
                            input int wi, input int wd);
        int n, last, cur, rk;
        int tp[2], tw[2], ts[2], tl[2], tr[2];
        logic [31:0] ta[2], twd[2], trd[2];
        logic [3:0]  tm[2];
        logic ri, rd;
        n = 0;
        if (has_d) begin tp[n] = 1; ta[n] = da; tm[n] = dm;   twd[n] = dw;    tw[n] = wd; n++; end
        if (has_i) begin tp[n] = 0; ta[n] = ia; tm[n] = 4'h0; twd[n] = 32'h0; tw[n] = wi; n++; end
        for (int k = 0; k < n; k++) begin
            ts[k]  = (k == 0) ? 0 : tr[k-1] + 1;
            tl[k]  = (tw[k] == 0) ? int'(TMO) : tw[k];
            tr[k]  = ts[k] + tl[k] + 1;
            trd[k] = ERRW;
        end
        last = tr[n-1] + 3;
        for (int c = 0; c <= last; c++) begin
            if (c >= 1) begin
                ri = 1'b0; rd = 1'b0; cur = -1; rk = -1;
                for (int k = 0; k < n; k++) begin
                    if (c > ts[k] && c <= ts[k] + tl[k]) cur = k;
                    if (c == tr[k]) begin
                        rk = k;
                        if (tp[k] == 1) rd = 1'b1; else ri = 1'b1;
                        if (tw[k] == 0) err_m = 1'b1;
                    end
                end
                chk("mem_req",    32'(bus.mem_req),    32'(cur >= 0));
                chk("imem_ready", 32'(bus.imem_ready), 32'(ri));
                chk("dmem_ready", 32'(bus.dmem_ready), 32'(rd));
                chk("bus_err",    32'(bus.bus_err),    32'(err_m));
                if (cur >= 0) begin
                    chk("mem_addr",  bus.mem_addr, {ta[cur][31:2], 2'b00});
                    chk("mem_wmask", 32'(bus.mem_wmask), 32'(tm[cur]));
                    if (tm[cur] != 4'h0) chk("mem_wdata", bus.mem_wdata, twd[cur]);
                end
                if (rk >= 0 && tm[rk] == 4'h0) begin
                    if (tp[rk] == 1) chk("dmem_rdata", bus.dmem_rdata, trd[rk]);
                    else             chk("imem_rdata", bus.imem_rdata, trd[rk]);
                end
            end
            // Core side: valid held through ready plus one; request fields scrambled after grant.
            bus.imem_valid = 1'b0; bus.imem_addr  = $urandom;
            bus.dmem_valid = 1'b0; bus.dmem_addr  = $urandom;
            bus.dmem_wmask = 4'($urandom); bus.dmem_wdata = $urandom; bus.dmem_rmask = 4'($urandom);
            for (int k = 0; k < n; k++) begin
                if (c <= tr[k] + 1) begin
                    if (tp[k] == 0) begin
                        bus.imem_valid = 1'b1;
                        if (c <= ts[k]) bus.imem_addr = ta[k];
                    end else begin
                        bus.dmem_valid = 1'b1;
                        if (c <= ts[k]) begin
                            bus.dmem_addr  = ta[k];
                            bus.dmem_wmask = tm[k];
                            bus.dmem_wdata = twd[k];
                            bus.dmem_rmask = (tm[k] == 4'h0) ? 4'hF : 4'h0;
                        end
                    end
                end
            end
            // Memory side: stray acks outside bus cycles must be ignored.
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            for (int k = 0; k < n; k++) begin
                if (c > ts[k] && c <= ts[k] + tl[k]) begin
                    bus.mem_ack = (tw[k] != 0) && (c == ts[k] + tw[k]);
                    if (bus.mem_ack) begin
                        trd[k] = mem_rd(ta[k]);
                        bus.mem_rdata = (tm[k] == 4'h0) ? trd[k] : $urandom;
                        if (tm[k] != 4'h0) mem_wr(ta[k], tm[k], twd[k]);
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] dm;
        int kind;
        reset = 1'b0; err_m = 1'b0;
        bus.imem_valid = 1'b0; bus.imem_addr = '0;
        bus.dmem_valid = 1'b0; bus.dmem_addr = '0; bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;   bus.dmem_rmask = '0;
        bus.mem_ack = 1'b0;    bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        scen = 1;
        chk_rst();
        reset = 1'b1;
        @(negedge clk);

        scen = 27;
        preload(32'h104, 32'h08123000);
        run_scen(1'b1, 1'b0, 32'h106, 32'h0, 4'h0, 32'h0, 2, 0);

        scen = 31;
        preload(32'h200, 32'h00001234);
        run_scen(1'b0, 1'b1, 32'h0, 32'h200, 4'h0, 32'h0, 0, 4);

        scen = 28;
        run_scen(1'b1, 1'b1, 32'h300, 32'h40, 4'hF, 32'h55AA55AA, 1, 2);
        scen = 281;
        run_scen(1'b0, 1'b1, 32'h0, 32'h40, 4'h0, 32'h0, 0, 3);

        scen = 30;
        run_scen(1'b0, 1'b1, 32'h0, 32'h80, 4'h0, 32'h0, 0, 0);
        scen = 301;
        run_scen(1'b1, 1'b1, 32'h84, 32'h88, 4'h3, 32'hA1B2C3D4, 2, 1);

        // Reset while a data read waits for an ack that only arrives after release.
        scen = 32;
        bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h500; bus.dmem_wmask = 4'h0;
        bus.imem_valid = 1'b0; bus.mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rstmid_mem_req", 32'(bus.mem_req), 32'h1);
        chk("rstmid_bus_err", 32'(bus.bus_err), 32'(err_m));
        @(posedge clk); @(negedge clk);
        reset = 1'b0; bus.dmem_valid = 1'b0;
        #1;
        chk_rst();
        @(posedge clk); @(negedge clk);
        reset = 1'b1; err_m = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk_rst();
        end
        bus.mem_ack = 1'b0;
        scen = 321;
        run_scen(1'b1, 1'b0, 32'h10C, 32'h0, 4'h0, 32'h0, 2, 0);

        for (int i = 0; i < 40; i++) begin
            scen = 200 + i;
            kind = int'($urandom_range(0, 2));
            dm   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_scen(kind != 1, kind != 0, {24'h0, 8'($urandom)}, {24'h0, 8'($urandom)},
                     dm, $urandom, pick_w(), pick_w());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mina_memarb.md
MINA_MEMARB -- requirements
Module: mina_memarb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles to wait for mem_ack before abort (range 1..255).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on abort.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have ports imem_valid in 1, imem_addr in 32, imem_ready out 1, imem_rdata out 32: core fetch port.
REQ-006 SHALL have ports dmem_valid in 1, dmem_addr in 32, dmem_wmask in 4, dmem_wdata in 32, dmem_rmask in 4, dmem_ready out 1, dmem_rdata out 32: core data port.
REQ-007 SHALL have ports mem_req out 1, mem_addr out 32, mem_wmask out 4, mem_wdata out 32, mem_ack in 1, mem_rdata in 32: single shared memory bus.
REQ-008 SHALL have port bus_err  out 1: sticky flag, set by any timeout abort.

Function
REQ-009 SHALL implement states IDLE, IBUS, DBUS, RESP.
REQ-010 In IDLE: dmem request takes priority; dmem_valid -> DBUS; else imem_valid -> IBUS; else stay.
REQ-011 On leaving IDLE: SHALL latch address, wmask (0 for imem), wdata; mem_addr = {addr[31:2],2'b00}; mem_req = 1 from the next cycle.
REQ-012 Latched request fields SHALL remain stable while mem_req is high, regardless of core inputs.
REQ-013 In IBUS/DBUS: mem_ack=1 SHALL drop mem_req, capture mem_rdata, and go to RESP.
REQ-014 In RESP: SHALL drive exactly one cycle of ready on the granted port, rdata = captured word, then go to IDLE.
REQ-015 Writes (wmask != 0) SHALL also complete with one ready pulse; rdata = captured mem_rdata, don't-care.
REQ-016 A wait counter SHALL clear on grant and increment each IBUS/DBUS cycle without ack; reaching TIMEOUT SHALL drop mem_req, capture ERR_DATA, set bus_err, and go to RESP.
REQ-017 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-018 mem_ack outside IBUS/DBUS SHALL be ignored.
REQ-019 The core holds valid one cycle past ready, so each port's valid SHALL be masked for the cycle after its ready pulse; total request-to-request gap >= 2 cycles.
REQ-020 Latency SHALL be grant cycle + ack wait + 1 RESP cycle; zero-wait memory (ack the cycle after mem_req rises) SHALL give ready 3 cycles after valid is first sampled.
REQ-021 imem_ready and dmem_ready SHALL never be high together; ready SHALL never be asserted without a prior valid.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 Asserting reset (0) SHALL immediately force IDLE and clear mem_req, mem_wmask, imem_ready, dmem_ready, bus_err, the counter, and the valid masks; address, data, and rdata registers clear to 0.
REQ-024 Reset mid-transaction SHALL abandon it with no ready pulse; a late mem_ack after release SHALL be ignored per REQ-018.

Structure
REQ-025 State encodings and the W_/M_ width constants SHALL live in the shared minaret defines header, used also by the minaret core.
REQ-026 The wait counter with its TIMEOUT compare SHALL be one sub-module, mina_wdog (inputs clear/enable, output expired); everything else is flat.

Verification
REQ-027 Single fetch: imem_valid, addr 0x00000106, ack after 2 cycles with rdata 0x08123000 -> mem_addr 0x00000104, mem_wmask 0, one imem_ready pulse with rdata 0x08123000.
REQ-028 Collision: imem_valid and dmem_valid (store 0x55AA55AA to 0x40, wmask 4'b1111) rise in the same cycle -> data transaction first with mem_wdata 0x55AA55AA, then fetch; ready pulses never overlap.
REQ-029 Held valid: core keeps imem_valid for one cycle after imem_ready -> exactly one bus transaction, not two.
REQ-030 Timeout: TIMEOUT=4, never ack -> mem_req drops after 4 wait cycles, dmem_rdata 0xDEADBEEF, bus_err=1 and stays 1 through later successful transactions.
REQ-031 Ack on expiry edge: TIMEOUT=4, ack in the 4th wait cycle with rdata 0x1234 -> rdata 0x1234, bus_err stays 0.
REQ-032 Reset mid-operation: reset low during DBUS wait, ack arrives after release -> no ready pulse, state IDLE, all outputs at reset values.
